// File: rtl/fp16_to_int16_pipe.sv
// fp16_to_int16_pipe
// Converts IEEE-754 half-precision values to signed 16-bit integers over a
// two-stage pipeline. Rounding is round-to-nearest-even. Out-of-range values
// and infinities clamp with sat=1. NaN yields 0 with nan=1.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready is the combinational advance enable
//   fp16_val             fp16 operand {sign, exp[4:0], mant[9:0]}
//   out_valid/out_ready  output handshake
//   int_val              two's-complement result
//   sat, nan, inexact    result flags, registered alongside int_val
//   sat_cnt              saturating count of consumed results that had sat=1
//   sat_cnt_clr          synchronous clear of sat_cnt; wins over an increment
module fp16_to_int16_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] fp16_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] int_val,
    output logic        sat,
    output logic        nan,
    output logic        inexact,
    output logic [7:0]  sat_cnt,
    input  logic        sat_cnt_clr
);

    logic        adv_s;
    logic [4:0]  exp_s;
    logic [9:0]  man_s;
    logic [10:0] sig_s;
    logic [4:0]  sh_s;
    logic [38:0] fix_s;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic        s1_nan_q,   s1_nan_d;
    logic        s1_satp_q,  s1_satp_d;
    logic [15:0] s1_int_q,   s1_int_d;
    logic        s1_g_q,     s1_g_d;
    logic        s1_r_q,     s1_r_d;
    logic        s1_s_q,     s1_s_d;

    logic        rnd_up_s;
    logic [16:0] mag_s;
    logic        ovf_s;
    logic        sat_s;
    logic [15:0] res_s;
    logic        inexact_s;

    logic        out_valid_q, out_valid_d;
    logic [15:0] int_val_q,   int_val_d;
    logic        sat_q,       sat_d;
    logic        nan_q,       nan_d;
    logic        inexact_q,   inexact_d;
    logic [7:0]  sat_cnt_q,   sat_cnt_d;

    // Whole pipeline moves together whenever the output slot is free or being drained.
    assign adv_s    = ~out_valid_q | out_ready;
    assign in_ready = adv_s;

    // Stage 1: unpack, classify and align the significand to a fixed point with 24 fraction bits.
    always_comb begin
        exp_s = fp16_val[14:10];
        man_s = fp16_val[9:0];
        // Subnormals have no hidden bit and share the scale of exponent 1.
        sig_s = {(exp_s != 5'd0), man_s};
        sh_s  = (exp_s == 5'd0) ? 5'd0 : (exp_s - 5'd1);
        // value * 2^24 = sig << (exp - 1); a single left shift covers both the
        // integer (exp >= 25) and fractional (exp < 25) cases. Only exp <= 29
        // uses this, so the integer part fits in fix_s[38:24].
        fix_s = {28'd0, sig_s} << sh_s;

        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_nan_d   = s1_nan_q;
        s1_satp_d  = s1_satp_q;
        s1_int_d   = s1_int_q;
        s1_g_d     = s1_g_q;
        s1_r_d     = s1_r_q;
        s1_s_d     = s1_s_q;

        if (adv_s) begin
            s1_valid_d = in_valid;
            s1_sign_d  = fp16_val[15];
            s1_nan_d   = (exp_s == 5'd31) && (man_s != 10'd0);
            // exp 30 and up is |v| >= 32768; only exactly -32768 is representable.
            s1_satp_d  = ((exp_s == 5'd31) && (man_s == 10'd0)) ||
                         ((exp_s == 5'd30) && !(fp16_val[15] && (man_s == 10'd0)));
            if (exp_s >= 5'd30) begin
                s1_int_d = 16'h8000;
                s1_g_d   = 1'b0;
                s1_r_d   = 1'b0;
                s1_s_d   = 1'b0;
            end else begin
                s1_int_d = {1'b0, fix_s[38:24]};
                s1_g_d   = fix_s[23];
                s1_r_d   = fix_s[22];
                s1_s_d   = |fix_s[21:0];
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: RNE rounding, range clamp and sign application.
    always_comb begin
        rnd_up_s = s1_g_q & (s1_r_q | s1_s_q | s1_int_q[0]);
        mag_s    = {1'b0, s1_int_q} + {16'd0, rnd_up_s};
        ovf_s    = s1_sign_q ? (mag_s > 17'd32768) : (mag_s > 17'd32767);
        sat_s    = ~s1_nan_q & (s1_satp_q | ovf_s);

        if (s1_nan_q) begin
            res_s = 16'd0;
        end else if (sat_s) begin
            res_s = s1_sign_q ? 16'h8000 : 16'h7FFF;
        end else if (s1_sign_q) begin
            // A zero magnitude negates to zero, so -0 never appears.
            res_s = 16'd0 - mag_s[15:0];
        end else begin
            res_s = mag_s[15:0];
        end

        inexact_s = ~s1_nan_q & ~sat_s & (s1_g_q | s1_r_q | s1_s_q);

        out_valid_d = out_valid_q;
        int_val_d   = int_val_q;
        sat_d       = sat_q;
        nan_d       = nan_q;
        inexact_d   = inexact_q;
        if (adv_s) begin
            out_valid_d = s1_valid_q;
            int_val_d   = res_s;
            sat_d       = sat_s;
            nan_d       = s1_nan_q;
            inexact_d   = inexact_s;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturation event counter: clear beats increment, holds at 255.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = 8'd0;
        end else if (out_valid_q && out_ready && sat_q && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // State registers for both stages and the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_satp_q   <= 1'b0;
            s1_int_q    <= 16'd0;
            s1_g_q      <= 1'b0;
            s1_r_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            out_valid_q <= 1'b0;
            int_val_q   <= 16'd0;
            sat_q       <= 1'b0;
            nan_q       <= 1'b0;
            inexact_q   <= 1'b0;
            sat_cnt_q   <= 8'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_nan_q    <= s1_nan_d;
            s1_satp_q   <= s1_satp_d;
            s1_int_q    <= s1_int_d;
            s1_g_q      <= s1_g_d;
            s1_r_q      <= s1_r_d;
            s1_s_q      <= s1_s_d;
            out_valid_q <= out_valid_d;
            int_val_q   <= int_val_d;
            sat_q       <= sat_d;
            nan_q       <= nan_d;
            inexact_q   <= inexact_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign int_val   = int_val_q;
    assign sat       = sat_q;
    assign nan       = nan_q;
    assign inexact   = inexact_q;
    assign sat_cnt   = sat_cnt_q;

endmodule
